if_stage: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core.
- Owns the architectural PC and drives it onto the instruction memory address input.
- Receives the memory's combinational instruction word and latches it, with PC metadata, into the IF/ID pipeline register.
- Handles sequential fetch, branch/jump/jr redirects, stalls, exception entry, eret return and fetch-address error detection.

---
 rtl/if_stage_pkg.sv | 16 +
 rtl/if_stage_if_id_reg.sv | 54 +++++
 rtl/if_stage.sv | 100 ++++++++++
 tb/tb_if_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: memory map constants and the NOP encoding.
package if_stage_pkg;

  localparam logic [31:0] PC_INIT      = 32'h0000_3000;
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
  localparam int          IM_WORDS     = 4096;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  // True when a fetch address is misaligned or outside instruction memory.
  function automatic logic fetchFault(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [32:0] limit);
    return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: loads on i_load, flushes to a NOP on i_flush, else holds.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_INIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic        i_bd,
  input  logic        i_adel,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc8,
  output logic        o_bd,
  output logic        o_adel
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_bd;
  logic        r_adel;

  // Flush outranks load so an exception squashes whatever was being fetched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= NOP_INSTR;
      r_pc    <= RESET_PC;
      r_bd    <= 1'b0;
      r_adel  <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_pc    <= i_flush_pc;
      r_bd    <= 1'b0;
      r_adel  <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_adel ? NOP_INSTR : i_instr;
      r_pc    <= i_pc;
      r_bd    <= i_bd;
      r_adel  <= i_adel;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pc8   = r_pc + 32'd8;
  assign o_bd    = r_bd;
  assign o_adel  = r_adel;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC priority mux, fetch fault detect.
// Optional macro IF_PERF_CNT_EN adds perf_fetch / perf_stall counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] P_PC_INIT      = PC_INIT,
  parameter logic [31:0] P_HANDLER_ADDR = HANDLER_ADDR,
  parameter int          P_IM_WORDS     = IM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_is_jump,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_bd,
  output logic        id_adel
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall
`endif
);

  localparam logic [32:0] PC_LIMIT = {1'b0, P_PC_INIT} + (33'(P_IM_WORDS) << 2);

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic        w_fault;
  logic        w_flush;
  logic        w_load;
  logic [31:0] w_flush_pc;

  assign w_fault    = fetchFault(r_pc, P_PC_INIT, PC_LIMIT);
  assign w_flush    = exc_req | eret_req;
  assign w_load     = ~w_flush & ~stall;
  assign w_flush_pc = exc_req ? P_HANDLER_ADDR : epc;

  // Priority: exception > eret > stall > redirect > sequential.
  always_comb begin
    w_pc_next = r_pc + 32'd4;
    if (exc_req)       w_pc_next = P_HANDLER_ADDR;
    else if (eret_req) w_pc_next = epc;
    else if (stall)    w_pc_next = r_pc;
    else if (redirect) w_pc_next = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) r_pc <= P_PC_INIT;
    else       r_pc <= w_pc_next;
  end

  assign pc = r_pc;

  if_id_reg #(
    .RESET_PC (P_PC_INIT)
  ) u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_flush_pc (w_flush_pc),
    .i_instr    (instr_in),
    .i_pc       (r_pc),
    .i_bd       (id_is_jump),
    .i_adel     (w_fault),
    .o_instr    (id_instr),
    .o_pc       (id_pc),
    .o_pc8      (id_pc8),
    .o_bd       (id_bd),
    .o_adel     (id_adel)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetch <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      if (w_load)            r_perf_fetch <= r_perf_fetch + 32'd1;
      if (stall && !w_flush) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch = r_perf_fetch;
  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: cycle-level reference model plus directed literal checks.
module tb_if_stage;

  localparam logic [31:0] PC_INIT_TB = 32'h0000_3000;
  localparam logic [31:0] HANDLER_TB = 32'h0000_4180;
  localparam longint      IM_BYTES   = 4 * 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_is_jump;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] instr_in;
  logic [31:0] pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic        id_bd;
  logic        id_adel;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
`endif

  int nCompared = 0;
  int nMismatch = 0;
  bit checkEn   = 1'b0;

  always #5 clk = ~clk;

  // Instruction memory contents: an arbitrary address-derived pattern.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0001;
  endfunction

  assign instr_in = memWord(pc);

  if_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_is_jump  (id_is_jump),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .instr_in    (instr_in),
    .pc          (pc),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc8      (id_pc8),
    .id_bd       (id_bd),
    .id_adel     (id_adel)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch  (perf_fetch),
    .perf_stall  (perf_stall)
`endif
  );

  // Reference model state, advanced once per rising edge.
  logic [31:0] mPc, mInstr, mIdPc;
  logic        mBd, mAdel;
  logic [31:0] mFetches, mStalls;

  always @(posedge clk) begin
    longint a;
    bit     bad;
    if (reset) begin
      mPc = PC_INIT_TB; mInstr = 0; mIdPc = PC_INIT_TB; mBd = 0; mAdel = 0;
      mFetches = 0; mStalls = 0;
    end else if (exc_req || eret_req) begin
      mPc    = exc_req ? HANDLER_TB : epc;
      mIdPc  = mPc;
      mInstr = 0; mBd = 0; mAdel = 0;
    end else if (stall) begin
      mStalls = mStalls + 1;
    end else begin
      a   = longint'(mPc);
      bad = (a % 4 != 0) || (a < longint'(PC_INIT_TB)) || (a >= longint'(PC_INIT_TB) + IM_BYTES);
      mIdPc    = mPc;
      mBd      = id_is_jump;
      mAdel    = bad;
      mInstr   = bad ? 32'd0 : memWord(mPc);
      mFetches = mFetches + 1;
      mPc      = redirect ? redirect_pc : mPc + 32'd4;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model.pc",       pc,       mPc);
      checkOutput("model.id_instr", id_instr, mInstr);
      checkOutput("model.id_pc",    id_pc,    mIdPc);
      checkOutput("model.id_pc8",   id_pc8,   mIdPc + 32'd8);
      checkOutput("model.id_bd",    {31'd0, id_bd},   {31'd0, mBd});
      checkOutput("model.id_adel",  {31'd0, id_adel}, {31'd0, mAdel});
`ifdef IF_PERF_CNT_EN
      checkOutput("model.perf_fetch", perf_fetch, mFetches);
      checkOutput("model.perf_stall", perf_stall, mStalls);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit st, input bit rd, input logic [31:0] rpc,
                               input bit jmp, input bit exc, input bit er,
                               input logic [31:0] e);
    stall = st; redirect = rd; redirect_pc = rpc; id_is_jump = jmp;
    exc_req = exc; eret_req = er; epc = e;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    stall = 0; redirect = 0; redirect_pc = 0; id_is_jump = 0;
    exc_req = 0; eret_req = 0; epc = 0;
    step(); step();
    checkOutput("reset.pc",       pc,       32'h3000);
    checkOutput("reset.id_instr", id_instr, 32'h0);
    checkOutput("reset.id_pc",    id_pc,    32'h3000);
    checkOutput("reset.id_pc8",   id_pc8,   32'h3008);
    checkOutput("reset.id_bd",    {31'd0, id_bd},   32'd0);
    checkOutput("reset.id_adel",  {31'd0, id_adel}, 32'd0);
    reset = 1'b0;
    checkEn = 1'b1;

    // Free run: 3004, 3008 then stall two cycles at 3008.
    idle(2);
    checkOutput("run.pc",       pc,       32'h3008);
    checkOutput("run.id_pc",    id_pc,    32'h3004);
    checkOutput("run.id_instr", id_instr, memWord(32'h3004));
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h3200, 0, 0, 0, 0);
    checkOutput("stall.pc",    pc,    32'h3008);
    checkOutput("stall.id_pc", id_pc, 32'h3004);
    idle(1);
    checkOutput("resume.pc", pc, 32'h300C);
    idle(1);

    // Redirect at 3010 with delay slot.
    applyStimulus(0, 1, 32'h3100, 1, 0, 0, 0);
    checkOutput("redir.pc",    pc,    32'h3100);
    checkOutput("redir.id_pc", id_pc, 32'h3010);
    checkOutput("redir.id_bd", {31'd0, id_bd}, 32'd1);
    idle(1);
    checkOutput("redir.next_pc", pc, 32'h3104);

    // Exception wins over stall and redirect.
    applyStimulus(1, 1, 32'h3300, 1, 1, 0, 0);
    checkOutput("exc.pc",       pc,       32'h4180);
    checkOutput("exc.id_instr", id_instr, 32'h0);
    checkOutput("exc.id_pc",    id_pc,    32'h4180);
    idle(1);
    checkOutput("exc.handler_fetch", id_instr, memWord(32'h4180));

    // eret, then exc and eret together.
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h3024);
    checkOutput("eret.pc",       pc,       32'h3024);
    checkOutput("eret.id_instr", id_instr, 32'h0);
    idle(1);
    checkOutput("eret.next_pc", pc, 32'h3028);
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h3040);
    checkOutput("exc_eret.pc", pc, 32'h4180);

    // Fetch faults: misaligned, below base, last legal word, just past end.
    applyStimulus(0, 1, 32'h3002, 1, 0, 0, 0);
    idle(1);
    checkOutput("misalign.adel",  {31'd0, id_adel}, 32'd1);
    checkOutput("misalign.instr", id_instr, 32'h0);
    checkOutput("misalign.pc",    pc,       32'h3006);
    applyStimulus(0, 1, 32'h2FFC, 0, 0, 0, 0);
    idle(1);
    checkOutput("below.adel", {31'd0, id_adel}, 32'd1);
    applyStimulus(0, 1, 32'h6FFC, 0, 0, 0, 0);
    idle(1);
    checkOutput("last.adel",  {31'd0, id_adel}, 32'd0);
    checkOutput("last.instr", id_instr, memWord(32'h6FFC));
    idle(1);
    checkOutput("end.adel", {31'd0, id_adel}, 32'd1);

    // PC wrap at 2^32.
    applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    idle(1);
    checkOutput("wrap.pc",   pc,    32'h0);
    checkOutput("wrap.id8",  id_pc8, 32'h0000_0004);

    // Reset mid-operation overrides a simultaneous exception.
    reset = 1'b1;
    applyStimulus(0, 1, 32'h3500, 1, 1, 0, 0);
    checkOutput("midreset.pc",       pc,       32'h3000);
    checkOutput("midreset.id_instr", id_instr, 32'h0);
    reset = 1'b0;
    idle(2);
    checkOutput("postreset.pc", pc, 32'h3008);
`ifdef IF_PERF_CNT_EN
    checkOutput("postreset.perf_fetch", perf_fetch, 32'd2);
`endif

    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
